dcache_ctrl_fsm: RTL and testbench

Parametrised main control FSM for the data cache. It sequences lookup, write-back, refill, uncached access and response for a WAYS-way, LINE_WORDS-per-line cache. Unlike the previous single-configuration controller, it owns the refill beat counter, overlaps victim write-back with the line refill, and flags AXI burst-length violations. It sits between the pipeline memory stage, the tag/data/dirty arrays and the AXI bridge.

---
 rtl/dcache_ctrl_fsm.sv | 197 +++++++++++++++++++
 tb/tb_dcache_ctrl_fsm.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl_fsm.sv
// Data-cache control FSM: lookup, overlapped victim write-back, counted line refill, uncached access.
// Hit responds 1 cycle after acceptance; AXI requests hold until ready, and refill beats are taken whenever valid.
module dcache_ctrl_fsm #(
  parameter int WAYS       = 4,
  parameter int LINE_WORDS = 16,
  parameter int WIDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  input  logic              req_op,
  input  logic              req_uncache,
  input  logic [2:0]        req_size,
  input  logic [WIDX_W-1:0] req_word,
  input  logic [WAYS-1:0]   tag_hit,
  input  logic [WAYS-1:0]   lru_way,
  input  logic              victim_dirty,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              rd_req,
  input  logic              rd_rdy,
  output logic [7:0]        rd_len,
  output logic [2:0]        rd_size,
  input  logic              rd_data_valid,
  input  logic              rd_last,
  output logic              rd_data_ready,
  output logic              wr_req,
  input  logic              wr_rdy,
  output logic [7:0]        wr_len,
  output logic [2:0]        wr_size,
  input  logic              wr_done,
  output logic              wb_capture,
  output logic [WAYS-1:0]   data_we,
  output logic [WAYS-1:0]   tag_we,
  output logic [WAYS-1:0]   dirty_we,
  output logic              dirty_val,
  output logic              fill_we,
  output logic [WIDX_W-1:0] fill_idx,
  output logic              fill_merge,
  output logic [WAYS-1:0]   way_sel,
  output logic              protocol_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOOKUP, S_WB_REQ, S_RD_REQ, S_REFILL, S_WB_WAIT, S_DONE
  } state_t;

  localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(LINE_WORDS - 1);
  localparam logic [7:0]        LINE_LEN = 8'(LINE_WORDS - 1);

  state_t              state_q;
  logic                wb_pend_q, wb_pend_d;
  logic                wb_out_q, wb_out_d;
  logic [WIDX_W-1:0]   cnt_q;
  logic                op_q, unc_q, err_q;
  logic [2:0]          size_q;
  logic [WIDX_W-1:0]   word_q;
  logic [WAYS-1:0]     lru_q;

  logic any_hit, cached_hit, lookup_miss, beat, is_last, wr_hs;

  assign any_hit      = |tag_hit;
  assign cached_hit   = (state_q == S_LOOKUP) && !unc_q && any_hit;
  assign lookup_miss  = (state_q == S_LOOKUP) && !unc_q && !any_hit;
  assign beat         = (state_q == S_REFILL) && rd_data_valid;
  // An uncached read is a single beat, so its first beat is always the last one.
  assign is_last      = unc_q || (cnt_q == LAST_IDX);
  assign wr_hs        = wr_req && wr_rdy;
  assign wb_pend_d    = lookup_miss ? victim_dirty : (wb_pend_q && !wr_rdy);
  assign wb_out_d     = wr_hs || (wb_out_q && !wr_done);
  assign fill_idx     = cnt_q;
  assign protocol_err = err_q;

  always_comb begin
    req_ready     = 1'b0;
    resp_valid    = 1'b0;
    rd_req        = 1'b0;
    rd_len        = 8'd0;
    rd_size       = 3'b010;
    rd_data_ready = 1'b0;
    wr_req        = 1'b0;
    wr_len        = 8'd0;
    wr_size       = 3'b010;
    wb_capture    = 1'b0;
    data_we       = '0;
    tag_we        = '0;
    dirty_we      = '0;
    dirty_val     = 1'b0;
    fill_we       = 1'b0;
    fill_merge    = 1'b0;
    way_sel       = '0;
    if (wb_pend_q) begin
      wr_req  = 1'b1;
      wr_len  = LINE_LEN;
      wr_size = 3'b010;
    end
    case (state_q)
      S_IDLE: req_ready = 1'b1;
      S_LOOKUP: begin
        if (cached_hit) begin
          resp_valid = 1'b1;
          req_ready  = 1'b1;
          way_sel    = tag_hit;
          if (op_q) begin
            data_we   = tag_hit;
            dirty_we  = tag_hit;
            dirty_val = 1'b1;
          end
        end else if (lookup_miss) begin
          wb_capture = victim_dirty;
        end else if (op_q) begin
          // Uncached store: the bypassed line copy must no longer be written back.
          wb_capture = 1'b1;
          dirty_we   = tag_hit;
        end
      end
      S_WB_REQ: begin
        wr_req  = 1'b1;
        wr_len  = 8'd0;
        wr_size = size_q;
      end
      S_RD_REQ: begin
        rd_req  = 1'b1;
        rd_len  = unc_q ? 8'd0 : LINE_LEN;
        rd_size = unc_q ? size_q : 3'b010;
      end
      S_REFILL: begin
        rd_data_ready = 1'b1;
        if (beat && !unc_q) begin
          fill_we    = 1'b1;
          fill_merge = op_q && (cnt_q == word_q);
          if (cnt_q == LAST_IDX) begin
            data_we   = lru_q;
            tag_we    = lru_q;
            dirty_we  = lru_q;
            dirty_val = op_q;
          end
        end
      end
      S_DONE: begin
        resp_valid = 1'b1;
        req_ready  = 1'b1;
        way_sel    = lru_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      wb_pend_q <= 1'b0;
      wb_out_q  <= 1'b0;
      cnt_q     <= '0;
      op_q      <= 1'b0;
      unc_q     <= 1'b0;
      size_q    <= 3'b010;
      word_q    <= '0;
      lru_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      wb_pend_q <= wb_pend_d;
      wb_out_q  <= wb_out_d;
      if (req_valid && req_ready) begin
        op_q   <= req_op;
        unc_q  <= req_uncache;
        size_q <= req_size;
        word_q <= req_word;
      end
      if (beat) begin
        cnt_q <= cnt_q + WIDX_W'(1);
        if (rd_last != is_last) err_q <= 1'b1;
      end
      case (state_q)
        S_IDLE:   if (req_valid) state_q <= S_LOOKUP;
        S_LOOKUP: begin
          if (cached_hit) begin
            state_q <= req_valid ? S_LOOKUP : S_IDLE;
          end else begin
            lru_q   <= lru_way;
            cnt_q   <= '0;
            state_q <= (unc_q && op_q) ? S_WB_REQ : S_RD_REQ;
          end
        end
        S_WB_REQ: if (wr_rdy) state_q <= S_WB_WAIT;
        S_RD_REQ: if (rd_rdy) state_q <= S_REFILL;
        S_REFILL: begin
          if (beat && is_last) state_q <= (wb_pend_d || wb_out_d) ? S_WB_WAIT : S_DONE;
        end
        S_WB_WAIT: if (!wb_pend_d && !wb_out_d) state_q <= S_DONE;
        S_DONE:   state_q <= req_valid ? S_LOOKUP : S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl_fsm.sv
// Scoreboard bench for dcache_ctrl_fsm: stimulus pushes expected responses, fill beats and AXI requests;
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_dcache_ctrl_fsm;
  localparam int WAYS = 4;
  localparam int LW   = 16;
  localparam int WW   = 4;

  logic clk = 1'b0;
  logic rstn;
  logic req_valid, req_op, req_uncache;
  logic [2:0] req_size;
  logic [WW-1:0] req_word;
  logic [WAYS-1:0] tag_hit, lru_way;
  logic victim_dirty;
  logic req_ready, resp_valid;
  logic rd_req, rd_rdy;
  logic [7:0] rd_len;
  logic [2:0] rd_size;
  logic rd_data_valid, rd_last, rd_data_ready;
  logic wr_req, wr_rdy;
  logic [7:0] wr_len;
  logic [2:0] wr_size;
  logic wr_done, wb_capture;
  logic [WAYS-1:0] data_we, tag_we, dirty_we;
  logic dirty_val, fill_we, fill_merge, protocol_err;
  logic [WW-1:0] fill_idx;
  logic [WAYS-1:0] way_sel;

  dcache_ctrl_fsm #(.WAYS(WAYS), .LINE_WORDS(LW)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_op(req_op), .req_uncache(req_uncache),
    .req_size(req_size), .req_word(req_word),
    .tag_hit(tag_hit), .lru_way(lru_way), .victim_dirty(victim_dirty),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .rd_req(rd_req), .rd_rdy(rd_rdy), .rd_len(rd_len), .rd_size(rd_size),
    .rd_data_valid(rd_data_valid), .rd_last(rd_last), .rd_data_ready(rd_data_ready),
    .wr_req(wr_req), .wr_rdy(wr_rdy), .wr_len(wr_len), .wr_size(wr_size),
    .wr_done(wr_done), .wb_capture(wb_capture),
    .data_we(data_we), .tag_we(tag_we), .dirty_we(dirty_we), .dirty_val(dirty_val),
    .fill_we(fill_we), .fill_idx(fill_idx), .fill_merge(fill_merge),
    .way_sel(way_sel), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] way;
    logic [3:0] dwe;
    logic [3:0] drwe;
    logic       dv;
    int         cyc;
    bit         chk_way;
  } resp_t;
  typedef struct {
    logic [3:0] idx;
    logic       merge;
    logic [3:0] dwe;
    logic [3:0] twe;
    logic [3:0] drwe;
    logic       dv;
  } fill_t;
  typedef struct {
    logic [7:0] len;
    logic [2:0] size;
  } axi_t;

  resp_t resp_q[$];
  fill_t fill_q[$];
  axi_t  rd_q[$];
  axi_t  wr_q[$];

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic unexpected(input string nm);
    total++;
    $display("FAIL %s: asserted with nothing expected", nm);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    resp_t er;
    fill_t ef;
    axi_t  ea;
    if (rstn === 1'b1) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) unexpected("resp_valid");
        else begin
          er = resp_q.pop_front();
          chk("resp_cycle", cyc, er.cyc);
          if (er.chk_way) chk("resp_way_sel", way_sel, er.way);
          chk("resp_data_we", data_we, er.dwe);
          chk("resp_dirty_we", dirty_we, er.drwe);
          chk("resp_dirty_val", dirty_val, er.dv);
        end
      end
      if (fill_we) begin
        if (fill_q.size() == 0) unexpected("fill_we");
        else begin
          ef = fill_q.pop_front();
          chk("fill_idx", fill_idx, ef.idx);
          chk("fill_merge", fill_merge, ef.merge);
          chk("fill_data_we", data_we, ef.dwe);
          chk("fill_tag_we", tag_we, ef.twe);
          chk("fill_dirty_we", dirty_we, ef.drwe);
          chk("fill_dirty_val", dirty_val, ef.dv);
        end
      end
      if (rd_req) begin
        if (rd_q.size() == 0) unexpected("rd_req");
        else if (rd_rdy) begin
          ea = rd_q.pop_front();
          chk("rd_len", rd_len, ea.len);
          chk("rd_size", rd_size, ea.size);
        end
      end
      if (wr_req) begin
        if (wr_q.size() == 0) unexpected("wr_req");
        else if (wr_rdy) begin
          ea = wr_q.pop_front();
          chk("wr_len", wr_len, ea.len);
          chk("wr_size", wr_size, ea.size);
        end
      end
    end
  end

  task automatic check_rst_outs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_rd_req"}, rd_req, 0);
    chk({tag, "_rd_len"}, rd_len, 0);
    chk({tag, "_rd_size"}, rd_size, 3'b010);
    chk({tag, "_rd_data_ready"}, rd_data_ready, 0);
    chk({tag, "_wr_req"}, wr_req, 0);
    chk({tag, "_wr_len"}, wr_len, 0);
    chk({tag, "_wr_size"}, wr_size, 3'b010);
    chk({tag, "_wb_capture"}, wb_capture, 0);
    chk({tag, "_array_we"}, {data_we, tag_we, dirty_we}, 0);
    chk({tag, "_dirty_val"}, dirty_val, 0);
    chk({tag, "_fill"}, {fill_we, fill_merge, fill_idx}, 0);
    chk({tag, "_way_sel"}, way_sel, 0);
    chk({tag, "_protocol_err"}, protocol_err, 0);
  endtask

  // Issues a cached request, answers LOOKUP with a miss and grants the AXI request(s) at once.
  task automatic start_miss(input logic op, input logic [3:0] word, input logic [3:0] lru,
                            input logic dirty, output int base);
    axi_t a;
    base        = cyc;
    req_valid   = 1'b1;
    req_op      = op;
    req_uncache = 1'b0;
    req_word    = word;
    tick;
    req_valid    = 1'b0;
    tag_hit      = 4'b0000;
    lru_way      = lru;
    victim_dirty = dirty;
    @(negedge clk);
    chk("miss_wb_capture", wb_capture, dirty);
    tick;
    lru_way      = 4'b0000;
    victim_dirty = 1'b0;
    a.len  = 8'd15;
    a.size = 3'b010;
    rd_q.push_back(a);
    if (dirty) wr_q.push_back(a);
    rd_rdy = 1'b1;
    wr_rdy = dirty;
    tick;
    rd_rdy = 1'b0;
    wr_rdy = 1'b0;
  endtask

  task automatic run_beats(input int n, input int last_pos, input logic [3:0] lru,
                           input logic op, input logic [3:0] word);
    for (int i = 0; i < n; i++) begin
      fill_t f;
      f.idx   = i[3:0];
      f.merge = op && (i == int'(word));
      f.dwe   = (i == LW - 1) ? lru : 4'b0000;
      f.twe   = f.dwe;
      f.drwe  = f.dwe;
      f.dv    = (i == LW - 1) ? op : 1'b0;
      fill_q.push_back(f);
      rd_data_valid = 1'b1;
      rd_last       = (i == last_pos);
      tick;
    end
    rd_data_valid = 1'b0;
    rd_last       = 1'b0;
  endtask

  task automatic push_resp(input logic [3:0] way, input logic [3:0] dwe, input logic [3:0] drwe,
                           input logic dv, input int at, input bit cw);
    resp_t r;
    r.way = way; r.dwe = dwe; r.drwe = drwe; r.dv = dv; r.cyc = at; r.chk_way = cw;
    resp_q.push_back(r);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b;
    axi_t a;
    rstn = 1'b0;
    req_valid = 0; req_op = 0; req_uncache = 0; req_size = 3'b010; req_word = 0;
    tag_hit = 0; lru_way = 0; victim_dirty = 0;
    rd_rdy = 0; rd_data_valid = 0; rd_last = 0; wr_rdy = 0; wr_done = 0;
    #2;
    check_rst_outs("rst0");
    tick;
    tick;
    rstn = 1'b1;
    tick;

    // Back-to-back hits: read way 2, then write way 0.
    b = cyc;
    push_resp(4'b0100, 4'b0000, 4'b0000, 1'b0, b + 1, 1'b1);
    push_resp(4'b0001, 4'b0001, 4'b0001, 1'b1, b + 2, 1'b1);
    req_valid = 1'b1; req_op = 1'b0; req_uncache = 1'b0; req_word = 0;
    tick;
    tag_hit = 4'b0100; req_op = 1'b1;
    tick;
    tag_hit = 4'b0001; req_valid = 1'b0; req_op = 1'b0;
    tick;
    tag_hit = 4'b0000;
    tick;

    // Cached read miss, clean victim in way 2.
    start_miss(1'b0, 4'd3, 4'b0100, 1'b0, b);
    push_resp(4'b0100, 4'b0000, 4'b0000, 1'b0, b + 19, 1'b1);
    run_beats(16, 15, 4'b0100, 1'b0, 4'd3);
    tick;
    tick;

    // Write miss to word 5, dirty victim in way 1; write response arrives 10 cycles after the last beat.
    start_miss(1'b1, 4'd5, 4'b0010, 1'b1, b);
    push_resp(4'b0010, 4'b0000, 4'b0000, 1'b0, b + 29, 1'b1);
    run_beats(16, 15, 4'b0010, 1'b1, 4'd5);
    repeat (9) tick;
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
    tick;
    tick;

    // Uncached byte store over a line held in way 2.
    b = cyc;
    a.len = 8'd0; a.size = 3'b000;
    wr_q.push_back(a);
    push_resp(4'b0000, 4'b0000, 4'b0000, 1'b0, b + 7, 1'b0);
    req_valid = 1'b1; req_op = 1'b1; req_uncache = 1'b1; req_size = 3'b000;
    tick;
    req_valid = 1'b0; tag_hit = 4'b0100;
    @(negedge clk);
    chk("unc_wb_capture", wb_capture, 1);
    chk("unc_dirty_we", dirty_we, 4'b0100);
    chk("unc_dirty_val", dirty_val, 0);
    tick;
    tag_hit = 4'b0000;
    tick;
    wr_rdy = 1'b1;
    tick;
    wr_rdy = 1'b0;
    tick;
    tick;
    wr_done = 1'b1;
    tick;
    wr_done = 1'b0;
    tick;
    req_uncache = 1'b0; req_size = 3'b010; req_op = 1'b0;
    tick;

    // Early rd_last on beat 7 of a 16-beat refill.
    chk("perr_before", protocol_err, 0);
    start_miss(1'b0, 4'd0, 4'b1000, 1'b0, b);
    push_resp(4'b1000, 4'b0000, 4'b0000, 1'b0, b + 19, 1'b1);
    run_beats(16, 7, 4'b1000, 1'b0, 4'd0);
    @(negedge clk);
    chk("perr_set", protocol_err, 1);
    tick;
    tick;

    // Reset dropped at beat 8 of a refill.
    start_miss(1'b0, 4'd0, 4'b0001, 1'b0, b);
    run_beats(8, 99, 4'b0001, 1'b0, 4'd0);
    chk("perr_sticky", protocol_err, 1);
    rstn = 1'b0;
    #1;
    check_rst_outs("rst_mid");
    tick;
    tick;
    rstn = 1'b1;
    tick;
    b = cyc;
    push_resp(4'b1000, 4'b0000, 4'b0000, 1'b0, b + 1, 1'b1);
    req_valid = 1'b1; req_op = 1'b0;
    tick;
    req_valid = 1'b0; tag_hit = 4'b1000;
    tick;
    tag_hit = 4'b0000;
    tick;
    tick;

    chk("resp_q_drained", resp_q.size(), 0);
    chk("fill_q_drained", fill_q.size(), 0);
    chk("rd_q_drained", rd_q.size(), 0);
    chk("wr_q_drained", wr_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
